// File: rtl/ibex_dummy_instr_reseed_pkg.sv
// Shared types and widths for the dummy-instruction reseed controller.
package ibex_dummy_instr_reseed_pkg;

    localparam int unsigned DummyReseedIntervalW = 8;
    localparam int unsigned DummyReseedTimeoutW  = 10;
    localparam int unsigned DummyReseedSeedW     = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StSeed = 2'd2
    } dummy_reseed_state_e;

endpackage

// File: rtl/ibex_dummy_instr_reseed.sv
// Reseed controller for the dummy-instruction LFSR: counts accepted insertions, fetches fresh
// entropy over a req/ack handshake after a programmed interval or a software request, and
// strobes the new seed into the generator for one cycle.
// Optional build macro: IBEX_DUMMY_RESEED_TIMEOUT_EN adds an entropy-wait timeout with a sticky
// error flag; without it the request waits indefinitely and the error output is tied low.
module ibex_dummy_instr_reseed
    import ibex_dummy_instr_reseed_pkg::*;
#(
    parameter int unsigned IntervalW = DummyReseedIntervalW,
    parameter int unsigned TimeoutW  = DummyReseedTimeoutW,
    parameter int unsigned SeedW     = DummyReseedSeedW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dummy_instr_en_i,
    input  logic [IntervalW-1:0] reseed_interval_i,
    input  logic                 sw_reseed_req_i,
    input  logic                 insert_dummy_instr_i,
    input  logic                 id_in_ready_i,
    output logic                 entropy_req_o,
    input  logic                 entropy_ack_i,
    input  logic [SeedW-1:0]     entropy_data_i,
    output logic                 seed_en_o,
    output logic [SeedW-1:0]     seed_o,
    output logic                 reseed_busy_o,
    output logic                 reseed_err_o
);

    dummy_reseed_state_e  state_q, state_d;
    logic [IntervalW-1:0] count_q, count_d, count_inc;
    logic                 pending_q, pending_d;
    logic [SeedW-1:0]     seed_q, seed_d;
    logic                 insert_accept;
    logic                 trigger;
    logic                 ack_taken;
    logic                 timeout_expire;

    assign insert_accept = insert_dummy_instr_i & id_in_ready_i & dummy_instr_en_i &
                           (state_q == StIdle);

    // Count including this cycle's insertion so the request follows the Nth insertion directly.
    assign count_inc = (insert_accept && (count_q != '1)) ? count_q + 1'b1 : count_q;

    // >= rather than == so lowering the interval below the current count still fires.
    assign trigger = (state_q == StIdle) &
                     (((reseed_interval_i != '0) & (count_inc >= reseed_interval_i)) |
                      sw_reseed_req_i | pending_q);

    assign ack_taken = (state_q == StReq) & entropy_ack_i;

`ifdef IBEX_DUMMY_RESEED_TIMEOUT_EN
    localparam logic [TimeoutW-1:0] TmoLast = {{(TimeoutW-1){1'b1}}, 1'b0};

    logic [TimeoutW-1:0] tmo_q, tmo_d;
    logic                err_q, err_d;

    // Expire when this ack-less REQ cycle would bring the counter to all-ones; ack wins a tie.
    assign timeout_expire = (state_q == StReq) & ~entropy_ack_i & (tmo_q == TmoLast);

    // Timeout counter and sticky error next-state.
    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (trigger) begin
            tmo_d = '0;
        end else if ((state_q == StReq) && !entropy_ack_i) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (timeout_expire) begin
            err_d = 1'b1;
        end else if (state_q == StSeed) begin
            err_d = 1'b0;
        end
    end

    // Timeout and error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign reseed_err_o = err_q;
`else
    logic [TimeoutW-1:0] unused_timeout_w;

    assign unused_timeout_w = '0;
    assign timeout_expire   = 1'b0;
    assign reseed_err_o     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (entropy_ack_i) begin
                    state_d = StSeed;
                end else if (timeout_expire) begin
                    state_d = StIdle;
                end
            end
            StSeed:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, decoded from the registered state only.
    always_comb begin
        entropy_req_o = 1'b0;
        seed_en_o     = 1'b0;
        reseed_busy_o = 1'b1;
        unique case (state_q)
            StIdle:  reseed_busy_o = 1'b0;
            StReq:   entropy_req_o = 1'b1;
            StSeed:  seed_en_o     = 1'b1;
            default: reseed_busy_o = 1'b0;
        endcase
    end

    // Insertion counter, pending software request and seed capture next-state.
    always_comb begin
        count_d   = count_inc;
        pending_d = pending_q;
        seed_d    = seed_q;
        if (ack_taken || timeout_expire) begin
            count_d = '0;
        end
        // A single request is remembered while busy; extra pulses collapse into it.
        if ((state_q != StIdle) && sw_reseed_req_i) begin
            pending_d = 1'b1;
        end
        if (trigger) begin
            pending_d = 1'b0;
        end
        if (ack_taken) begin
            seed_d = entropy_data_i;
        end
    end

    // Counter, pending flag and seed registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            pending_q <= 1'b0;
            seed_q    <= '0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            seed_q    <= seed_d;
        end
    end

    assign seed_o = seed_q;

endmodule

// File: tb/tb_ibex_dummy_instr_reseed.sv
// Directed and randomized bench for ibex_dummy_instr_reseed.
// Define IBEX_DUMMY_RESEED_TIMEOUT_EN for both files to exercise the timeout path.
module tb_ibex_dummy_instr_reseed;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  interval = 8'd0;
    logic        sw = 1'b0;
    logic        ins = 1'b0;
    logic        rdy = 1'b0;
    logic        req;
    logic        ack = 1'b0;
    logic [31:0] data = 32'd0;
    logic        seed_en;
    logic [31:0] seed;
    logic        busy;
    logic        err;

    int unsigned passed = 0;
    int unsigned total = 0;

    always #5 clk = ~clk;

    ibex_dummy_instr_reseed dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .dummy_instr_en_i     (en),
        .reseed_interval_i    (interval),
        .sw_reseed_req_i      (sw),
        .insert_dummy_instr_i (ins),
        .id_in_ready_i        (rdy),
        .entropy_req_o        (req),
        .entropy_ack_i        (ack),
        .entropy_data_i       (data),
        .seed_en_o            (seed_en),
        .seed_o               (seed),
        .reseed_busy_o        (busy),
        .reseed_err_o         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        total = total + 1;
        assert (obs === exp_v) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total = total + 1;
        assert (obs === exp_v) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Deliver one ack with the given data; expect a single seed strobe then idle.
    task automatic do_ack(input string tag, input logic [31:0] d);
        data = d;
        ack  = 1'b1;
        tick();
        ack = 1'b0;
        chk1({tag, "_seed_en"}, seed_en, 1'b1);
        chk32({tag, "_seed"}, seed, d);
        chk1({tag, "_req_low"}, req, 1'b0);
        tick();
        chk1({tag, "_seed_en_once"}, seed_en, 1'b0);
        chk1({tag, "_idle"}, busy, 1'b0);
        chk32({tag, "_seed_hold"}, seed, d);
    endtask

    task automatic sw_pulse();
        sw = 1'b1;
        tick();
        sw = 1'b0;
    endtask

    initial begin
        int unsigned iv;
        int unsigned acc;
        int unsigned dly;
        logic        hit;
        logic [31:0] rnd;

        // Reset values.
        #1;
        chk1("rst_req", req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_seed_en", seed_en, 1'b0);
        chk32("rst_seed", seed, 32'd0);
        chk1("rst_err", err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Interval 4: request follows the 4th accepted insertion.
        en = 1'b1;
        interval = 8'd4;
        ins = 1'b1;
        rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk1("int4_req", req, (i == 4));
        end
        ins = 1'b0;
        chk1("int4_busy", busy, 1'b1);
        do_ack("int4", 32'hA5A5_1234);

        // Not ready: nothing counts.
        ins = 1'b1;
        rdy = 1'b0;
        repeat (10) tick();
        chk1("noready_req", req, 1'b0);

        // Interval 0: 300 insertions never request, count saturates at 255.
        interval = 8'd0;
        rdy = 1'b1;
        repeat (300) tick();
        chk1("int0_req", req, 1'b0);
        ins = 1'b0;
        interval = 8'd255;
        tick();
        chk1("sat_req", req, 1'b1);
        interval = 8'd0;
        do_ack("sat", 32'h1111_2222);

        // Two software pulses while busy produce exactly one further reseed.
        sw_pulse();
        chk1("sw_req", req, 1'b1);
        sw_pulse();
        tick();
        sw_pulse();
        chk1("sw_req_held", req, 1'b1);
        do_ack("sw1", 32'h0BAD_F00D);
        tick();
        chk1("sw_pending_req", req, 1'b1);
        do_ack("sw2", 32'h600D_CAFE);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("sw_no_third", req, 1'b0);
        end

        // Ack outside REQ is ignored.
        data = 32'hDEAD_BEEF;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk1("stray_seed_en", seed_en, 1'b0);
        chk32("stray_seed", seed, 32'h600D_CAFE);
        chk1("stray_busy", busy, 1'b0);

        // Interval lowered below the current count fires on the next cycle.
        interval = 8'd10;
        ins = 1'b1;
        repeat (5) tick();
        ins = 1'b0;
        chk1("lower_before", req, 1'b0);
        interval = 8'd3;
        tick();
        chk1("lower_req", req, 1'b1);
        do_ack("lower", 32'h3333_4444);

        // Count holds while disabled.
        ins = 1'b1;
        repeat (2) tick();
        en = 1'b0;
        repeat (5) tick();
        chk1("hold_disabled", req, 1'b0);
        en = 1'b1;
        ins = 1'b0;
        tick();
        chk1("hold_resume", req, 1'b0);
        ins = 1'b1;
        tick();
        ins = 1'b0;
        chk1("hold_third", req, 1'b1);
        do_ack("hold", 32'h5555_6666);
        interval = 8'd0;

        // Reset mid-handshake drops everything asynchronously; a stray ack afterwards is ignored.
        sw_pulse();
        chk1("mid_req", req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_req", req, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk32("arst_seed", seed, 32'd0);
        tick();
        rst = 1'b0;
        data = 32'h7777_8888;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk1("post_rst_seed_en", seed_en, 1'b0);
        chk32("post_rst_seed", seed, 32'd0);

        // Randomized rounds: reseed once the running tally of accepted insertions meets the
        // interval, then ack after a random wait with random data.
        for (int r = 0; r < 6; r++) begin
            iv = $urandom_range(1, 8);
            interval = iv[7:0];
            acc = 0;
            hit = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                ins = 1'($urandom_range(0, 1));
                rdy = 1'($urandom_range(0, 1));
                if (ins && rdy) acc = acc + 1;
                tick();
                hit = (acc >= iv);
                chk1("rnd_req", req, hit);
            end
            ins = 1'b0;
            interval = 8'd0;
            dly = $urandom_range(0, 4);
            for (int d = 0; d < int'(dly); d++) begin
                tick();
                chk1("rnd_wait_req", req, 1'b1);
            end
            rnd = $urandom;
            do_ack("rnd", rnd);
        end

`ifdef IBEX_DUMMY_RESEED_TIMEOUT_EN
        // No ack for 1023 request cycles: error, request dropped, back to idle.
        sw_pulse();
        chk1("tmo_req", req, 1'b1);
        repeat (1022) tick();
        chk1("tmo_last_req", req, 1'b1);
        chk1("tmo_last_err", err, 1'b0);
        tick();
        chk1("tmo_req_drop", req, 1'b0);
        chk1("tmo_err", err, 1'b1);
        chk1("tmo_idle", busy, 1'b0);
        // Successful retry clears the error.
        sw_pulse();
        do_ack("retry", 32'h9999_AAAA);
        chk1("retry_err_clr", err, 1'b0);
        // Ack on the expiry cycle wins.
        sw_pulse();
        repeat (1022) tick();
        do_ack("tie", 32'hBBBB_CCCC);
        chk1("tie_err", err, 1'b0);
`else
        // Without a timeout the request waits indefinitely.
        sw_pulse();
        repeat (1100) tick();
        chk1("wait_req", req, 1'b1);
        chk1("wait_err", err, 1'b0);
        do_ack("late", 32'h9999_AAAA);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ibex_dummy_instr_reseed.md
Name: ibex_dummy_instr_reseed

Overview:
Upstream reseed controller for the dummy-instruction generator; drives its seed_en/seed inputs.
- Counts accepted dummy-instruction insertions.
- After a CSR-programmed number of insertions, or on a software request, fetches 32 bits of fresh entropy over a req/ack handshake.
- Issues a one-cycle seed update toward the LFSR.
- Sits between the CSR/entropy interface and the dummy-instruction generator inside the core.

Parameters:
IntervalW, 8, width of reseed interval CSR field and insertion counter
TimeoutW, 10, width of entropy-wait timeout counter (used only with optional feature)
SeedW, 32, width of entropy data and seed output

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
dummy_instr_en_i  in  1  dummy insertion enabled (CSR)
reseed_interval_i  in  IntervalW  insertions between reseeds; 0 = automatic reseed disabled
sw_reseed_req_i  in  1  single-cycle software reseed request
insert_dummy_instr_i  in  1  generator is presenting a dummy instruction
id_in_ready_i  in  1  ID stage accepts instruction this cycle
entropy_req_o  out  1  entropy request
entropy_ack_i  in  1  entropy valid/ack, single cycle
entropy_data_i  in  SeedW  entropy, valid when ack high
seed_en_o  out  1  one-cycle seed strobe to generator
seed_o  out  SeedW  seed value, registered
reseed_busy_o  out  1  FSM not IDLE
reseed_err_o  out  1  sticky timeout error

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state IDLE.
  - all outputs 0; seed_o = 0.
  - insertion count = 0; pending flag = 0; timeout count = 0.
- Insertion count (IntervalW bits):
  - Increments when insert_dummy_instr_i & id_in_ready_i & dummy_instr_en_i in IDLE.
  - Saturates at all-ones; never wraps.
  - Cleared on every transition to SEED or to IDLE after timeout.
  - Holds while dummy_instr_en_i = 0.
- Trigger in IDLE is either of:
  - reseed_interval_i != 0 and count >= reseed_interval_i. A compare of >= covers the interval being lowered below the current count.
  - sw_reseed_req_i or pending flag set.
- sw_reseed_req_i while not IDLE sets the pending flag. Only one request is held; further pulses are dropped. The flag clears on entry to REQ.
- FSM states:
  - IDLE: on trigger -> REQ next cycle.
  - REQ:
    - entropy_req_o = 1, held high until ack (or timeout).
    - On entropy_ack_i: capture entropy_data_i into seed_o -> SEED.
    - dummy_instr_en_i dropping does not abort; the handshake completes.
  - SEED:
    - seed_en_o = 1 for exactly one cycle; seed_o stable.
    - Clear reseed_err_o -> IDLE.
- Latency: trigger cycle N -> req high N+1. Ack at cycle M -> seed_en_o at M+1 -> busy low at M+2.
- entropy_ack_i outside REQ is ignored; seed_o is unchanged.
- seed_o is updated only on accepted ack and holds its value otherwise.
- rst_i mid-handshake: immediate return to reset values, req dropped asynchronously.

Optional Feature:
IBEX_DUMMY_RESEED_TIMEOUT_EN
- Defined:
  - Timeout counter (TimeoutW bits) clears on REQ entry and increments each REQ cycle without ack.
  - At all-ones without ack: set reseed_err_o, drop req, clear insertion count -> IDLE.
  - Retry happens at the next trigger.
  - Ack in the same cycle as expiry: ack wins and is taken normally, no error.
- Undefined: REQ waits indefinitely; reseed_err_o is tied 0; no timeout logic.

Decomposition:
- ibex_pkg:
  - dummy_reseed_state_e enum (IDLE, REQ, SEED), 2 bits.
  - DummyReseedIntervalW = 8.
  - DummyReseedTimeoutW = 10.
- No sub-module needed. FSM, counters and seed register all fit in one module. The timeout counter sits inside the macro guard.

Test Plan:
- Interval=4, en=1, 4 accepted insertions (ready high) -> req rises the cycle after the 4th. Ack with data 0xA5A5_1234 -> seed_en_o one cycle next cycle, seed_o=0xA5A5_1234, count=0.
- Insertions with id_in_ready_i=0 -> no count; interval=0 with 300 insertions -> count saturates at 255, no req.
- sw_reseed_req_i pulsed twice while in REQ -> after SEED, exactly one further req cycle sequence; no third.
- With TIMEOUT_EN, no ack for 1023 REQ cycles -> err=1, req=0, IDLE. Next successful reseed -> err=0. Ack on the expiry cycle -> no error.
- rst_i asserted while req high -> req, busy, seed_o all 0 asynchronously; spurious ack after reset -> no seed_en_o.
- Interval lowered from 10 to 3 when count=5 -> req the next cycle.
